// File: rtl/external_stimulus_player.sv
// Buffers time-stamped stimulus events and replays each one on its synapse row when the timestamp counter reaches the event time.
// Latency: one cycle from release to the registered stim pulse. Backpressure: evt_ready drops when the FIFO is full and the head is not popping.
module external_stimulus_player #(
    parameter int NUM_SYNAPSE_ROWS = 1,
    parameter int ADDR_WIDTH       = 6,
    parameter int TIME_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 16,
    localparam int ROW_W           = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
    localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   run,
    input  logic                                   time_clear,
    input  logic                                   evt_valid,
    output logic                                   evt_ready,
    input  logic [TIME_WIDTH-1:0]                  evt_time,
    input  logic [ROW_W-1:0]                       evt_row,
    input  logic [ADDR_WIDTH-1:0]                  evt_address,
    input  logic                                   evt_on_off,
    output logic [NUM_SYNAPSE_ROWS-1:0]            stim_valid,
    output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] stim_address,
    output logic [NUM_SYNAPSE_ROWS-1:0]            stim_on_off,
    output logic [TIME_WIDTH-1:0]                  now,
    output logic [CNT_W-1:0]                       fifo_count,
    output logic                                   late_event,
    output logic                                   bad_row
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [TIME_WIDTH-1:0] rel_time;
        logic [ROW_W-1:0]      row;
        logic [ADDR_WIDTH-1:0] address;
        logic                  on_off;
    } evt_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    evt_t                  mem [FIFO_DEPTH];
    evt_t                  head;
    evt_t                  wr_dat;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [TIME_WIDTH-1:0] time_diff;
    logic                  due;
    logic                  push;
    logic                  pop;
    logic [NUM_SYNAPSE_ROWS-1:0] row_hit;

    assign head   = mem[rd_ptr];
    assign wr_dat = '{rel_time: evt_time, row: evt_row, address: evt_address, on_off: evt_on_off};

    // Wrap-safe "now >= time": the difference must land in the lower half of the counter range.
    assign time_diff = now - head.rel_time;
    assign due       = ~time_diff[TIME_WIDTH-1];

    assign pop       = (state == ARMED) && run && due;
    assign evt_ready = (fifo_count != CNT_W'(FIFO_DEPTH)) || pop;
    assign push      = evt_valid && evt_ready;

    always_comb begin
        row_hit = '0;
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            row_hit[r] = pop && ({{(32-ROW_W){1'b0}}, head.row} == 32'(r));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push) state_next = ARMED;
            ARMED:   if (pop && !push && fifo_count == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)           now <= '0;
        else if (time_clear) now <= '0;
        else if (run)        now <= now + TIME_WIDTH'(1);
    end

    // Address and on/off of a row persist until that row is released again.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim_valid   <= '0;
            stim_address <= '0;
            stim_on_off  <= '0;
            late_event   <= 1'b0;
            bad_row      <= 1'b0;
        end else begin
            stim_valid <= row_hit;
            for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                if (row_hit[r]) begin
                    stim_address[r*ADDR_WIDTH +: ADDR_WIDTH] <= head.address;
                    stim_on_off[r]                           <= head.on_off;
                end
            end
            if (pop && time_diff != '0) late_event <= 1'b1;
            if (pop && row_hit == '0)   bad_row    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_external_stimulus_player.sv
// Scoreboard bench: every accepted event with a valid row queues its expected pulse, and the monitor pops and compares on each stim pulse.
module tb_external_stimulus_player;

    localparam int NR = 5;
    localparam int AW = 6;
    localparam int TW = 16;
    localparam int FD = 16;
    localparam int RW = 3;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           run;
    logic           time_clear;
    logic           evt_valid;
    logic           evt_ready;
    logic [TW-1:0]  evt_time;
    logic [RW-1:0]  evt_row;
    logic [AW-1:0]  evt_address;
    logic           evt_on_off;
    logic [NR-1:0]  stim_valid;
    logic [NR*AW-1:0] stim_address;
    logic [NR-1:0]  stim_on_off;
    logic [TW-1:0]  now;
    logic [CW-1:0]  fifo_count;
    logic           late_event;
    logic           bad_row;

    typedef struct {
        int row;
        int addr;
        int on;
        int rel;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    external_stimulus_player #(
        .NUM_SYNAPSE_ROWS(NR),
        .ADDR_WIDTH(AW),
        .TIME_WIDTH(TW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .time_clear(time_clear),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_time(evt_time),
        .evt_row(evt_row),
        .evt_address(evt_address),
        .evt_on_off(evt_on_off),
        .stim_valid(stim_valid),
        .stim_address(stim_address),
        .stim_on_off(stim_on_off),
        .now(now),
        .fifo_count(fifo_count),
        .late_event(late_event),
        .bad_row(bad_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulses appear one cycle after release, so the release time is now - 1.
    always @(negedge clk) begin
        if (stim_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'(stim_valid), 64'd0);
            end else begin
                exp_t e;
                logic [NR-1:0] exp_v;
                logic [TW-1:0] rel_now;
                e       = sb.pop_front();
                exp_v   = NR'(1) << e.row;
                rel_now = now - TW'(1);
                check("pulse_row", 64'(stim_valid), 64'(exp_v));
                check("pulse_addr", 64'(stim_address[e.row*AW +: AW]), 64'(e.addr));
                check("pulse_on_off", 64'(stim_on_off[e.row]), 64'(e.on));
                check("pulse_time", 64'(rel_now), 64'(e.rel));
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        run        = 1'b0;
        time_clear = 1'b0;
        evt_valid  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input int t, input int row, input int addr, input int on,
                        input bit expect_pulse, input int rel);
        bit acc;
        acc         = 1'b0;
        evt_valid   = 1'b1;
        evt_time    = TW'(t);
        evt_row     = RW'(row);
        evt_address = AW'(addr);
        evt_on_off  = on[0];
        for (int i = 0; i < 200 && !acc; i++) begin
            #1;
            acc = evt_ready;
            @(negedge clk);
        end
        evt_valid = 1'b0;
        if (!acc) check("push_timeout", 64'd0, 64'd1);
        else if (expect_pulse) sb.push_back('{row, addr, on, rel});
    endtask

    task automatic wait_now(input int v, input int bound);
        for (int i = 0; i < bound && now != TW'(v); i++) @(negedge clk);
        check("wait_now", 64'(now), 64'(v));
    endtask

    initial begin
        evt_time    = '0;
        evt_row     = '0;
        evt_address = '0;
        evt_on_off  = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_stim_valid", 64'(stim_valid), 64'd0);
        check("rst_now", 64'(now), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_late", 64'(late_event), 64'd0);
        check("rst_bad_row", 64'(bad_row), 64'd0);
        check("rst_ready", 64'(evt_ready), 64'd1);

        // Single event released exactly on time
        run = 1'b1;
        push(5, 0, 3, 1, 1'b1, 5);
        wait_now(10, 50);
        check("t1_late", 64'(late_event), 64'd0);
        check("t1_sb_drained", 64'(sb.size()), 64'd0);

        // Head-of-line ordering across rows with late releases
        do_reset();
        push(10, 2, 10, 0, 1'b1, 10);
        push(10, 1, 20, 1, 1'b1, 11);
        push(11, 3, 30, 1, 1'b1, 12);
        run = 1'b1;
        wait_now(15, 50);
        check("t2_late", 64'(late_event), 64'd1);
        check("t2_bad_row", 64'(bad_row), 64'd0);
        check("t2_hold_addr_r2", 64'(stim_address[2*AW +: AW]), 64'd10);
        check("t2_hold_addr_r1", 64'(stim_address[1*AW +: AW]), 64'd20);
        check("t2_hold_on_r3", 64'(stim_on_off[3]), 64'd1);

        // Fill the FIFO while frozen, then drain back-to-back
        do_reset();
        for (int i = 0; i < FD; i++) push(100, i % NR, i + 1, i % 2, 1'b1, 100 + i);
        check("t3_full_count", 64'(fifo_count), 64'(FD));
        #1;
        check("t3_full_ready", 64'(evt_ready), 64'd0);
        check("t3_frozen_now", 64'(now), 64'd0);
        @(negedge clk);
        run = 1'b1;
        wait_now(120, 200);
        check("t3_drained", 64'(fifo_count), 64'd0);
        check("t3_sb_drained", 64'(sb.size()), 64'd0);

        // Out-of-range row is dropped
        do_reset();
        run = 1'b1;
        push(0, 5, 7, 1, 1'b0, 0);
        repeat (4) @(negedge clk);
        check("t5_bad_row", 64'(bad_row), 64'd1);
        check("t5_count", 64'(fifo_count), 64'd0);

        // Reset while the head is due
        do_reset();
        push(0, 1, 1, 1, 1'b0, 0);
        push(0, 2, 2, 1, 1'b0, 0);
        push(0, 3, 3, 1, 1'b0, 0);
        check("t6_queued", 64'(fifo_count), 64'd3);
        run   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_stim_valid", 64'(stim_valid), 64'd0);
        check("t6_count", 64'(fifo_count), 64'd0);
        check("t6_now", 64'(now), 64'd0);
        check("t6_ready", 64'(evt_ready), 64'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_bad_row", 64'(bad_row), 64'd0);

        // Timestamp wrap
        do_reset();
        run = 1'b1;
        repeat (3) @(negedge clk);
        time_clear = 1'b1;
        @(negedge clk);
        time_clear = 1'b0;
        check("t4_clear", 64'(now), 64'd0);
        wait_now(65532, 70000);
        push(1, 4, 45, 1, 1'b1, 1);
        wait_now(5, 100);
        check("t4_count", 64'(fifo_count), 64'd0);
        check("t4_late", 64'(late_event), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/external_stimulus_player.md
Name: external_stimulus_player

Overview:
- Upstream feeder of the external-stimulus inputs of the external spike router.
- Accepts time-stamped stimulus events from the testbench or host over a valid/ready stream and buffers them in an internal FIFO.
- Releases each event on the addressed synapse row's spike_in-style outputs (valid, address, on_off) once a free-running timestamp counter reaches the event's time.
- Releases at most one event per cycle; outputs are registered.

Parameters:
- NUM_SYNAPSE_ROWS, 1, number of synapse rows; number of per-row output channels.
- ADDR_WIDTH, 6, width of the spike address carried per row.
- TIME_WIDTH, 16, width of the timestamp counter and of event times.
- FIFO_DEPTH, 16, event buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = timestamp counter advances and events may be released; 0 = freeze both.
- time_clear  in  1  synchronous clear of the timestamp counter to 0.
- evt_valid  in  1  input event valid.
- evt_ready  out  1  input event accepted when valid and ready are both 1.
- evt_time  in  TIME_WIDTH  release time.
- evt_row  in  max(1,$clog2(NUM_SYNAPSE_ROWS))  target synapse row.
- evt_address  in  ADDR_WIDTH  spike address.
- evt_on_off  in  1  on/off flag forwarded unchanged.
- stim_valid  out  NUM_SYNAPSE_ROWS  per-row one-cycle release pulse.
- stim_address  out  NUM_SYNAPSE_ROWS*ADDR_WIDTH  per-row address; row r occupies bits [r*ADDR_WIDTH +: ADDR_WIDTH].
- stim_on_off  out  NUM_SYNAPSE_ROWS  per-row on/off flag.
- now  out  TIME_WIDTH  current timestamp counter value.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- late_event  out  1  sticky; set when an event is released with now != evt_time.
- bad_row  out  1  sticky; set when an event with evt_row >= NUM_SYNAPSE_ROWS is dropped.

Behaviour:
- Reset:
  - Outputs: stim_* = 0, now = 0, fifo_count = 0, late_event = 0, bad_row = 0, evt_ready = 1.
  - FIFO is emptied.
  - Reset mid-operation discards all buffered events; no stim pulse appears in the cycle after reset is asserted.
- Timestamp counter:
  - time_clear has priority: next now = 0.
  - Otherwise, when run = 1: now <= now + 1, wrapping modulo 2^TIME_WIDTH.
- FIFO write side:
  - evt_ready = (fifo_count < FIFO_DEPTH), or head pop in the same cycle. Write-through on full while popping is allowed.
  - Push on evt_valid & evt_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Release condition for the head entry H:
  - FIFO not empty, run = 1, and due(H).
  - due(H) = ((now - H.time) mod 2^TIME_WIDTH) < 2^(TIME_WIDTH-1). This is wrap-safe "now >= time" over half the range.
  - Events are released strictly in FIFO order; the head blocks later events even if those are due.
- Release action:
  - Pop the head.
  - If H.row < NUM_SYNAPSE_ROWS: next cycle, stim_valid[H.row] = 1, stim_address[H.row] = H.address, stim_on_off[H.row] = H.on_off. Latency is exactly 1 cycle from the release cycle.
  - If H.row is out of range: no output pulse; set bad_row.
  - If now != H.time at release: set late_event.
- Output holding:
  - stim_valid is a single-cycle pulse; all other bits of stim_valid are 0.
  - stim_address and stim_on_off of a row hold their last value until that row is next released.
- run = 0: no pops, counter frozen; pushes still accepted.
- Simultaneous time_clear and release:
  - The release is evaluated against the pre-clear now.
  - Entries whose time is now in the future stay queued.
- Empty FIFO: no stim activity.
- Full FIFO without a pop: evt_ready = 0; the input must hold its event.
- FSM, two states:
  - IDLE: FIFO empty.
  - ARMED: FIFO non-empty.
  - IDLE -> ARMED on push; ARMED -> IDLE on pop leaving the FIFO empty with no simultaneous push.
  - The state is purely derived, but is implemented explicitly and used for release gating.

Test Plan:
- Reset, then run = 1 and push {time = 5, row = 0, addr = 3, on = 1} -> stim_valid = 4'b0001, address 3, on_off 1 in the cycle after now = 5. Exactly one pulse; late_event stays 0.
- NUM_SYNAPSE_ROWS = 4, push times 10, 10, 11 to rows 2, 1, 3 -> pulses on row 2 after now = 10, row 1 after now = 11, row 3 after now = 12. late_event = 1 (row-1 and row-3 events released late).
- Push FIFO_DEPTH = 16 events with time = 100 while run = 0 -> fifo_count = 16, evt_ready = 0. On run = 1 at now = 0, no pulses until now = 100, then 16 consecutive one-cycle pulses.
- Wrap case: TIME_WIDTH = 16, clear, run to now = 65534, push time = 1 -> no release at 65534 or 65535. Release at now = 1 after wrap, pulse one cycle later.
- Push row = 5 with NUM_SYNAPSE_ROWS = 4, time = 0 -> event popped, no stim_valid bit set, bad_row = 1, fifo_count returns to 0.
- Assert reset with 3 queued events while the head is due -> the next cycle has stim_valid = 0, fifo_count = 0, now = 0, and evt_ready = 1 from the first post-reset cycle.
